// File: rtl/ddr_cntrl_if.sv
// Bus between the AXI slave bridge (master) and the DDR controller model (slave).
// The command is implied by pwrite and logical_addr; there is no separate valid.
interface ddr_cntrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   logical_addr;
    logic [DATA_W-1:0]   pwdata;
    logic                pwrite;
    logic [DATA_W/8-1:0] strobe;
    logic [3:0]          burstlen;
    logic [DATA_W-1:0]   prdata;

    modport master (
        output logical_addr, pwdata, pwrite, strobe, burstlen,
        input  prdata
    );

    modport slave (
        input  logical_addr, pwdata, pwrite, strobe, burstlen,
        output prdata
    );
endinterface

// File: rtl/ddr_cntrl.sv
// Simplified DDR controller model: strobed write bursts into a word array,
// single-word reads returned after a fixed pipeline latency.
//
//   state | meaning
//   IDLE  | waiting for a burst start; beat 0 is written in the start cycle
//   WRITE | writing beats 1..burstlen at waddr, abort when pwrite drops
module ddr_cntrl #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int MEM_WORDS    = 256,
    parameter int READ_LATENCY = 1
) (
    input logic       clk,
    input logic       rst,
    ddr_cntrl_if.slave bus
);
    localparam int WORD_W = $clog2(MEM_WORDS);
    localparam int LANES  = DATA_W / 8;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t             state;
    logic [WORD_W-1:0]  waddr;
    logic [3:0]         remaining;
    logic               pwrite_q;
    logic [ADDR_W-1:0]  last_addr;
    logic [DATA_W-1:0]  prdata;

    logic [DATA_W-1:0]  mem [MEM_WORDS];

    logic [WORD_W-1:0]  word_idx;
    logic [WORD_W-1:0]  wr_idx;
    logic               start;
    logic               wr_en;
    logic               rd_en;
    logic [DATA_W-1:0]  rd_sample;
    logic [DATA_W-1:0]  tail_dat;
    logic               tail_vld;

    assign word_idx  = bus.logical_addr[2 +: WORD_W];
    assign start     = (state == IDLE) && bus.pwrite &&
                       (!pwrite_q || (bus.logical_addr != last_addr));
    // Writes are blocked while reset is held so a dropped burst leaves no trace.
    assign wr_en     = rst && (start || ((state == WRITE) && bus.pwrite));
    assign wr_idx    = (state == IDLE) ? word_idx : waddr;
    assign rd_en     = !bus.pwrite;
    assign rd_sample = mem[word_idx];
    assign bus.prdata = prdata;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.strobe[i]) begin
                    mem[wr_idx][8*i +: 8] <= bus.pwdata[8*i +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign tail_dat = rd_sample;
            assign tail_vld = rd_en;
        end else begin : g_latn
            logic [DATA_W-1:0]       pipe_dat [READ_LATENCY-1];
            logic [READ_LATENCY-2:0] pipe_vld;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_vld <= '0;
                    for (int i = 0; i < READ_LATENCY-1; i++) begin
                        pipe_dat[i] <= '0;
                    end
                end else begin
                    pipe_vld[0] <= rd_en;
                    pipe_dat[0] <= rd_sample;
                    for (int i = 1; i < READ_LATENCY-1; i++) begin
                        pipe_vld[i] <= pipe_vld[i-1];
                        pipe_dat[i] <= pipe_dat[i-1];
                    end
                end
            end

            assign tail_dat = pipe_dat[READ_LATENCY-2];
            assign tail_vld = pipe_vld[READ_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            waddr     <= '0;
            remaining <= '0;
            pwrite_q  <= 1'b0;
            last_addr <= '0;
            prdata    <= '0;
        end else begin
            pwrite_q  <= bus.pwrite;
            last_addr <= bus.logical_addr;
            if (tail_vld) begin
                prdata <= tail_dat;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        waddr     <= word_idx + WORD_W'(1);
                        remaining <= bus.burstlen;
                        if (bus.burstlen != 4'd0) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (!bus.pwrite) begin
                        state <= IDLE;
                    end else begin
                        waddr     <= waddr + WORD_W'(1);
                        remaining <= remaining - 4'd1;
                        if (remaining == 4'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_cntrl.sv
// Bench for ddr_cntrl: vector table with a read-data scoreboard, plus
// hand-written reset sequences.
module tb_ddr_cntrl;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ddr_cntrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    ddr_cntrl #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(256), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        pw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  blen;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] exp;
        logic [31:0] due;
        logic [15:0] id;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic void wr(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [3:0] b);
        vecs.push_back('{1'b1, a, d, s, b, 1'b0, 32'h0});
    endfunction

    function automatic void rd(input logic [31:0] a, input logic c, input logic [31:0] e);
        vecs.push_back('{1'b0, a, 32'h0, 4'h0, 4'h0, c, e});
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: prdata=%08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
            e = sb.pop_front();
            check_val($sformatf("vec%0d", e.id), bus.prdata, e.exp);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        @(negedge clk);
        drain();
        bus.pwrite       = v.pw;
        bus.logical_addr = v.addr;
        bus.pwdata       = v.wdata;
        bus.strobe       = v.strb;
        bus.burstlen     = v.blen;
        if (!v.pw && v.chk) sb.push_back('{v.exp, 32'(cyc_cnt + LAT), 16'(id)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pwrite       = 1'b1;
        bus.logical_addr = 32'h40;
        bus.pwdata       = 32'hA5A5_A5A5;
        bus.strobe       = 4'hF;
        bus.burstlen     = 4'd0;
        #12;
        check_val("reset", bus.prdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Constant address with pwrite held: only the first edge writes.
        apply('{1'b1, 32'h40, 32'hA5A5_A5A5, 4'hF, 4'd0, 1'b0, 32'h0}, 900);
        for (int i = 0; i < 3; i++)
            apply('{1'b1, 32'h40, 32'h5A5A_5A5A, 4'hF, 4'd0, 1'b0, 32'h0}, 901);
        @(negedge clk);
        check_val("idle_hold", bus.prdata, 32'h0);

        rd(32'h40, 1, 32'hA5A5_A5A5);
        wr(32'h10, 32'hDEAD_BEEF, 4'hF, 4'd0);
        rd(32'h10, 1, 32'hDEAD_BEEF);
        wr(32'h0, 32'h1111_1111, 4'hF, 4'd3);
        wr(32'h0, 32'h2222_2222, 4'hF, 4'd0);
        wr(32'h0, 32'h3333_3333, 4'hF, 4'd0);
        wr(32'h0, 32'h4444_4444, 4'hF, 4'd0);
        rd(32'h0, 1, 32'h1111_1111);
        rd(32'h4, 1, 32'h2222_2222);
        rd(32'h8, 1, 32'h3333_3333);
        rd(32'hC, 1, 32'h4444_4444);
        wr(32'h20, 32'hAABB_CCDD, 4'hF, 4'd0);
        rd(32'h20, 1, 32'hAABB_CCDD);
        wr(32'h20, 32'h1122_3344, 4'b0101, 4'd0);
        rd(32'h20, 1, 32'hAA22_CC44);
        wr(32'h3FC, 32'hA000_0001, 4'hF, 4'd2);
        wr(32'h3FC, 32'hA000_0002, 4'hF, 4'd0);
        wr(32'h3FC, 32'hA000_0003, 4'hF, 4'd0);
        rd(32'h3FC, 1, 32'hA000_0001);
        rd(32'h0,   1, 32'hA000_0002);
        rd(32'h4,   1, 32'hA000_0003);
        rd(32'h400, 1, 32'hA000_0002);
        wr(32'h3FC, 32'hB000_0001, 4'hF, 4'd2);
        wr(32'h3FC, 32'hB000_0002, 4'hF, 4'd0);
        rd(32'h4,   1, 32'hA000_0003);
        rd(32'h3FC, 1, 32'hB000_0001);
        rd(32'h0,   1, 32'hB000_0002);
        wr(32'h84, 32'h1234_5678, 4'hF, 4'd0);
        rd(32'h84, 0, 32'h0);
        wr(32'h80, 32'hC0C0_C0C0, 4'hF, 4'd1);
        wr(32'h80, 32'hFFFF_FFFF, 4'h0, 4'd0);
        wr(32'h88, 32'h7777_7777, 4'hF, 4'd0);
        rd(32'h84, 1, 32'h1234_5678);
        rd(32'h88, 1, 32'h7777_7777);
        rd(32'h80, 1, 32'hC0C0_C0C0);
        wr(32'h108, 32'h0BAD_F00D, 4'hF, 4'd0);
        rd(32'h108, 0, 32'h0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset between edges in the middle of a burst.
        apply('{1'b0, 32'h10, 32'h0, 4'h0, 4'd0, 1'b1, 32'hDEAD_BEEF}, 100);
        apply('{1'b1, 32'h100, 32'hD000_0001, 4'hF, 4'd3, 1'b0, 32'h0}, 101);
        apply('{1'b1, 32'h100, 32'hD000_0002, 4'hF, 4'd0, 1'b0, 32'h0}, 102);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_val("async_rst", bus.prdata, 32'h0);
        bus.logical_addr = 32'h108;
        bus.pwdata       = 32'hD000_0003;
        @(posedge clk);
        #1 rst = 1'b1;
        apply('{1'b1, 32'h100, 32'hE000_0001, 4'hF, 4'd0, 1'b0, 32'h0}, 103);
        apply('{1'b0, 32'h100, 32'h0, 4'h0, 4'd0, 1'b1, 32'hE000_0001}, 104);
        apply('{1'b0, 32'h104, 32'h0, 4'h0, 4'd0, 1'b1, 32'hD000_0002}, 105);
        apply('{1'b0, 32'h108, 32'h0, 4'h0, 4'd0, 1'b1, 32'h0BAD_F00D}, 106);

        repeat (LAT + 2) begin
            @(negedge clk);
            drain();
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL timeout vec%0d: no read data, expected %08h", e.id, e.exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
